// File: rtl/vga_pkg.sv
// Shared raster timing constants, coordinate width and the sync/active control bundle
// used by the VGA timing generator and its delay line.
package vga_pkg;

  localparam int COORD_W     = 12;
  localparam int COORD_LIMIT = 4096;

  // 1280x1024 @ 60 Hz, 108 MHz pixel clock
  localparam int SXGA_H_VIS  = 1280;
  localparam int SXGA_H_FP   = 48;
  localparam int SXGA_H_SYNC = 112;
  localparam int SXGA_H_BP   = 248;
  localparam int SXGA_V_VIS  = 1024;
  localparam int SXGA_V_FP   = 1;
  localparam int SXGA_V_SYNC = 3;
  localparam int SXGA_V_BP   = 38;

  // 640x480 @ 60 Hz, 25 MHz pixel clock
  localparam int VGA_H_VIS   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_V_VIS   = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_ctrl_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register for the active/HS/VS bundle; DEPTH clocks of latency.
// Resets to the idle bundle (inactive, syncs deasserted); depth 0 is a gated bypass.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH    = 1,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  vga_ctrl_t ctrl_i,
  output vga_ctrl_t ctrl_o
);

  localparam vga_ctrl_t IDLE = '{active: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk;
      assign unused_clk = clk_i;
      // Without a register stage, reset still has to force the idle bundle.
      assign ctrl_o = rst_ni ? ctrl_i : IDLE;
    end else begin : g_shift
      vga_ctrl_t stage_q [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= IDLE;
        end else begin
          stage_q[0] <= ctrl_i;
          for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign ctrl_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter with sync/active decode, a configurable flag delay line, a frame tick
// and a frame counter. Coordinates and frame_tick are registered outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS      = SXGA_H_VIS,
  parameter int unsigned H_FP       = SXGA_H_FP,
  parameter int unsigned H_SYNC     = SXGA_H_SYNC,
  parameter int unsigned H_BP       = SXGA_H_BP,
  parameter int unsigned V_VIS      = SXGA_V_VIS,
  parameter int unsigned V_FP       = SXGA_V_FP,
  parameter int unsigned V_SYNC     = SXGA_V_SYNC,
  parameter int unsigned V_BP       = SXGA_V_BP,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic               CLK_VGA,
  input  logic               RST_N,
  output logic [COORD_W-1:0] VGA_horzCoord,
  output logic [COORD_W-1:0] VGA_vertCoord,
  output logic               VGA_active,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               frame_tick,
  output logic [7:0]         frame_count
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int          CMP_W   = COORD_W + 1;

  generate
    if (H_TOTAL > COORD_LIMIT) begin : g_h_total_too_large
      $error("vga_timing_gen: H_TOTAL exceeds 12-bit coordinate range");
    end
    if (V_TOTAL > COORD_LIMIT) begin : g_v_total_too_large
      $error("vga_timing_gen: V_TOTAL exceeds 12-bit coordinate range");
    end
    if (SYNC_DELAY > 4) begin : g_sync_delay_too_large
      $error("vga_timing_gen: SYNC_DELAY must be 0..4");
    end
  endgenerate

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  // Thresholds carry one extra bit so a sync window ending at 4096 still compares correctly.
  localparam logic [CMP_W-1:0] H_VIS_C    = CMP_W'(H_VIS);
  localparam logic [CMP_W-1:0] HS_START_C = CMP_W'(H_VIS + H_FP);
  localparam logic [CMP_W-1:0] HS_END_C   = CMP_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] V_VIS_C    = CMP_W'(V_VIS);
  localparam logic [CMP_W-1:0] VS_START_C = CMP_W'(V_VIS + V_FP);
  localparam logic [CMP_W-1:0] VS_END_C   = CMP_W'(V_VIS + V_FP + V_SYNC);

  logic [COORD_W-1:0] horz_q, horz_d;
  logic [COORD_W-1:0] vert_q, vert_d;
  logic               tick_q, tick_d;
  logic [7:0]         count_q, count_d;
  logic               h_wrap;

  always_comb begin
    h_wrap  = (horz_q == H_LAST);
    horz_d  = h_wrap ? '0 : horz_q + COORD_W'(1);
    vert_d  = vert_q;
    if (h_wrap) begin
      vert_d = (vert_q == V_LAST) ? '0 : vert_q + COORD_W'(1);
    end
    // Tick is computed from next-state coords so the register lines up with them.
    tick_d  = (horz_d == H_LAST) && (vert_d == V_LAST);
    count_d = tick_q ? count_q + 8'd1 : count_q;
  end

  always_ff @(posedge CLK_VGA or negedge RST_N) begin
    if (!RST_N) begin
      horz_q  <= '0;
      vert_q  <= '0;
      tick_q  <= 1'b0;
      count_q <= '0;
    end else begin
      horz_q  <= horz_d;
      vert_q  <= vert_d;
      tick_q  <= tick_d;
      count_q <= count_d;
    end
  end

  logic [CMP_W-1:0] horz_ext, vert_ext;
  logic             in_hsync, in_vsync;
  vga_ctrl_t        raw_ctrl, dly_ctrl;

  always_comb begin
    horz_ext        = {1'b0, horz_q};
    vert_ext        = {1'b0, vert_q};
    in_hsync        = (horz_ext >= HS_START_C) && (horz_ext < HS_END_C);
    in_vsync        = (vert_ext >= VS_START_C) && (vert_ext < VS_END_C);
    raw_ctrl.active = (horz_ext < H_VIS_C) && (vert_ext < V_VIS_C);
    raw_ctrl.hs     = in_hsync ? SYNC_POL : ~SYNC_POL;
    raw_ctrl.vs     = in_vsync ? SYNC_POL : ~SYNC_POL;
  end

  vga_delay_line #(
    .DEPTH    (SYNC_DELAY),
    .SYNC_POL (SYNC_POL)
  ) u_delay (
    .clk_i  (CLK_VGA),
    .rst_ni (RST_N),
    .ctrl_i (raw_ctrl),
    .ctrl_o (dly_ctrl)
  );

  assign VGA_horzCoord = horz_q;
  assign VGA_vertCoord = vert_q;
  assign VGA_active    = dly_ctrl.active;
  assign VGA_HS        = dly_ctrl.hs;
  assign VGA_VS        = dly_ctrl.vs;
  assign frame_tick    = tick_q;
  assign frame_count   = count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench on a reduced 20x12 raster with three builds (SYNC_DELAY 0, 1, 3).
module tb_vga_timing_gen;

  localparam int HV = 10, HF = 2, HSW = 3, HB = 5, HT = 20;
  localparam int VV = 6,  VF = 1, VSW = 2, VB = 3, VT = 12;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] h0, v0, h1, v1, h3, v3;
  logic        a0, a1, a3, hs0, hs1, hs3, vs0, vs1, vs3, t0, t1, t3;
  logic [7:0]  c0, c1, c3;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int tick_total = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                   .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                   .SYNC_POL(1'b1), .SYNC_DELAY(0)) dut_d0 (
    .CLK_VGA(clk), .RST_N(rst_n), .VGA_horzCoord(h0), .VGA_vertCoord(v0),
    .VGA_active(a0), .VGA_HS(hs0), .VGA_VS(vs0), .frame_tick(t0), .frame_count(c0));

  vga_timing_gen #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                   .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                   .SYNC_POL(1'b1), .SYNC_DELAY(1)) dut_d1 (
    .CLK_VGA(clk), .RST_N(rst_n), .VGA_horzCoord(h1), .VGA_vertCoord(v1),
    .VGA_active(a1), .VGA_HS(hs1), .VGA_VS(vs1), .frame_tick(t1), .frame_count(c1));

  vga_timing_gen #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                   .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                   .SYNC_POL(1'b1), .SYNC_DELAY(3)) dut_d3 (
    .CLK_VGA(clk), .RST_N(rst_n), .VGA_horzCoord(h3), .VGA_vertCoord(v3),
    .VGA_active(a3), .VGA_HS(hs3), .VGA_VS(vs3), .frame_tick(t3), .frame_count(c3));

  // Reference raster as a function of clocks since reset release (k < 0 means still idle).
  function automatic logic [11:0] m_h(int k); return 12'(k % HT); endfunction
  function automatic logic [11:0] m_v(int k); return 12'((k / HT) % VT); endfunction
  function automatic logic m_act(int k);
    if (k < 0) return 1'b0;
    return ((k % HT) < HV) && (((k / HT) % VT) < VV);
  endfunction
  function automatic logic m_hs(int k);
    if (k < 0) return 1'b0;
    return ((k % HT) >= HV + HF) && ((k % HT) < HV + HF + HSW);
  endfunction
  function automatic logic m_vs(int k);
    if (k < 0) return 1'b0;
    return (((k / HT) % VT) >= VV + VF) && (((k / HT) % VT) < VV + VF + VSW);
  endfunction
  function automatic logic m_tick(int k); return (k % FR) == FR - 1; endfunction
  function automatic logic [7:0] m_cnt(int k); return 8'((k / FR) % 256); endfunction

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 7;
    if (h1 !== 12'd0 || v1 !== 12'd0) begin errors++; $display("FAIL rst_coord got %0d,%0d exp 0,0", h1, v1); end
    if (a0 !== 1'b0 || a1 !== 1'b0 || a3 !== 1'b0) begin errors++; $display("FAIL rst_active got %b%b%b exp 000", a0, a1, a3); end
    if (hs0 !== 1'b0 || hs1 !== 1'b0 || hs3 !== 1'b0) begin errors++; $display("FAIL rst_hs got %b%b%b exp 000", hs0, hs1, hs3); end
    if (vs0 !== 1'b0 || vs1 !== 1'b0 || vs3 !== 1'b0) begin errors++; $display("FAIL rst_vs got %b%b%b exp 000", vs0, vs1, vs3); end
    if (t0 !== 1'b0 || t1 !== 1'b0 || t3 !== 1'b0) begin errors++; $display("FAIL rst_tick got %b%b%b exp 000", t0, t1, t3); end
    if (c1 !== 8'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", c1); end
    if (h0 !== 12'd0 || h3 !== 12'd0) begin errors++; $display("FAIL rst_coord_other got %0d,%0d exp 0,0", h0, h3); end
  endtask

  task automatic test_release();
    rst_n = 1'b1;
    n = 0;
    #1;
    checks += 3;
    if (h1 !== 12'd0 || v1 !== 12'd0) begin errors++; $display("FAIL rel_coord0 got %0d,%0d exp 0,0", h1, v1); end
    if (a1 !== 1'b0) begin errors++; $display("FAIL rel_a1_first got %b exp 0", a1); end
    if (a0 !== 1'b1) begin errors++; $display("FAIL rel_a0_first got %b exp 1", a0); end
    step();
    checks += 3;
    if (h1 !== 12'd1 || v1 !== 12'd0) begin errors++; $display("FAIL rel_coord1 got %0d,%0d exp 1,0", h1, v1); end
    if (a1 !== 1'b1) begin errors++; $display("FAIL rel_a1_second got %b exp 1", a1); end
    if (a3 !== 1'b0) begin errors++; $display("FAIL rel_a3_second got %b exp 0", a3); end
    step();
    step();
    checks++;
    if (a3 !== 1'b1) begin errors++; $display("FAIL rel_a3_fourth got %b exp 1", a3); end
  endtask

  task automatic test_line();
    int rise0 = -1, rise1 = -1, rise3 = -1;
    int fall1 = -1;
    while (n < 2 * HT) begin
      step();
      checks += 5;
      if (h1 !== m_h(n) || v1 !== m_v(n)) begin errors++; $display("FAIL line_coord n=%0d got %0d,%0d exp %0d,%0d", n, h1, v1, m_h(n), m_v(n)); end
      if (h0 !== h1 || h3 !== h1 || v0 !== v1 || v3 !== v1) begin errors++; $display("FAIL line_coord_builds n=%0d got %0d %0d %0d", n, h0, h1, h3); end
      if ({a0, a1, a3} !== {m_act(n), m_act(n-1), m_act(n-3)}) begin errors++; $display("FAIL line_active n=%0d got %b%b%b exp %b%b%b", n, a0, a1, a3, m_act(n), m_act(n-1), m_act(n-3)); end
      if ({hs0, hs1, hs3} !== {m_hs(n), m_hs(n-1), m_hs(n-3)}) begin errors++; $display("FAIL line_hs n=%0d got %b%b%b exp %b%b%b", n, hs0, hs1, hs3, m_hs(n), m_hs(n-1), m_hs(n-3)); end
      if (n == HT && (h1 !== 12'd0 || v1 !== 12'd1)) begin errors++; $display("FAIL line_wrap got %0d,%0d exp 0,1", h1, v1); end
      if (hs0 && rise0 < 0) rise0 = n;
      if (hs1 && rise1 < 0) rise1 = n;
      if (hs3 && rise3 < 0) rise3 = n;
      if (!a1 && fall1 < 0) fall1 = n;
    end
    checks += 4;
    if (rise0 != 12) begin errors++; $display("FAIL hs_rise_d0 got %0d exp 12", rise0); end
    if (rise1 != 13) begin errors++; $display("FAIL hs_rise_d1 got %0d exp 13", rise1); end
    if (rise3 != 15) begin errors++; $display("FAIL hs_rise_d3 got %0d exp 15", rise3); end
    if (fall1 != 11) begin errors++; $display("FAIL active_fall_d1 got %0d exp 11", fall1); end
  endtask

  task automatic test_frame();
    int tick_a = -1, tick_b = -1, vs_clocks = 0;
    while (n < 2 * FR) begin
      step();
      checks += 4;
      if ({vs0, vs1, vs3} !== {m_vs(n), m_vs(n-1), m_vs(n-3)}) begin errors++; $display("FAIL frame_vs n=%0d got %b%b%b exp %b%b%b", n, vs0, vs1, vs3, m_vs(n), m_vs(n-1), m_vs(n-3)); end
      if ({t0, t1, t3} !== {3{m_tick(n)}}) begin errors++; $display("FAIL frame_tick n=%0d got %b%b%b exp %b", n, t0, t1, t3, m_tick(n)); end
      if (c1 !== m_cnt(n) || c0 !== c1 || c3 !== c1) begin errors++; $display("FAIL frame_count n=%0d got %0d exp %0d", n, c1, m_cnt(n)); end
      if (h1 !== m_h(n) || v1 !== m_v(n)) begin errors++; $display("FAIL frame_coord n=%0d got %0d,%0d exp %0d,%0d", n, h1, v1, m_h(n), m_v(n)); end
      if (t1) begin
        tick_total++;
        if (tick_a < 0) tick_a = n; else if (tick_b < 0) tick_b = n;
      end
      if (vs0 && n < FR) vs_clocks++;
    end
    checks += 3;
    if (tick_a != 239) begin errors++; $display("FAIL first_tick_cycle got %0d exp 239", tick_a); end
    if (tick_b != 479) begin errors++; $display("FAIL frame_period got %0d exp 240", tick_b - tick_a); end
    if (vs_clocks != 40) begin errors++; $display("FAIL vs_width got %0d exp 40", vs_clocks); end
  endtask

  task automatic test_count_wrap();
    while (n < 256 * FR + 2) begin
      step();
      checks += 2;
      if (t1 !== m_tick(n)) begin errors++; $display("FAIL wrap_tick n=%0d got %b exp %b", n, t1, m_tick(n)); end
      if (c1 !== m_cnt(n)) begin errors++; $display("FAIL wrap_count n=%0d got %0d exp %0d", n, c1, m_cnt(n)); end
      if (n == 256 * FR - 1) begin checks++; if (c1 !== 8'd255) begin errors++; $display("FAIL count_255 got %0d exp 255", c1); end end
      if (n == 256 * FR) begin checks++; if (c1 !== 8'd0) begin errors++; $display("FAIL count_wrap0 got %0d exp 0", c1); end end
      if (t1) tick_total++;
    end
    checks++;
    if (tick_total != 256) begin errors++; $display("FAIL tick_total got %0d exp 256", tick_total); end
  endtask

  task automatic test_reset_mid();
    while (n < 256 * FR + 4 * HT + 13) step();
    checks += 2;
    if (h1 !== 12'd13 || v1 !== 12'd4) begin errors++; $display("FAIL mid_pos got %0d,%0d exp 13,4", h1, v1); end
    if (hs1 !== 1'b1) begin errors++; $display("FAIL mid_hs_pre got %b exp 1", hs1); end
    #1 rst_n = 1'b0;
    #1;
    checks += 4;
    if (h0 !== 12'd0 || h1 !== 12'd0 || h3 !== 12'd0 || v1 !== 12'd0) begin errors++; $display("FAIL mid_async_coord got %0d,%0d exp 0,0", h1, v1); end
    if ({hs0, hs1, hs3, vs0, vs1, vs3} !== 6'b0) begin errors++; $display("FAIL mid_async_sync got %b%b%b exp 000", hs0, hs1, hs3); end
    if ({a0, a1, a3} !== 3'b0) begin errors++; $display("FAIL mid_async_active got %b%b%b exp 000", a0, a1, a3); end
    if (c1 !== 8'd0) begin errors++; $display("FAIL mid_async_count got %0d exp 0", c1); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (t1 !== 1'b0 || h1 !== 12'd0) begin errors++; $display("FAIL mid_hold i=%0d got tick %b h %0d exp tick 0 h 0", i, t1, h1); end
    end
    rst_n = 1'b1;
    n = 0;
    #1;
    checks++;
    if (h1 !== 12'd0 || v1 !== 12'd0) begin errors++; $display("FAIL mid_restart0 got %0d,%0d exp 0,0", h1, v1); end
    step();
    checks += 2;
    if (h1 !== 12'd1 || v1 !== 12'd0) begin errors++; $display("FAIL mid_restart1 got %0d,%0d exp 1,0", h1, v1); end
    if (a1 !== 1'b1 || c1 !== 8'd0) begin errors++; $display("FAIL mid_restart_flags got a %b c %0d exp a 1 c 0", a1, c1); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_line();
    test_frame();
    test_count_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
